// File: rtl/huffman_pkg.sv
// Shared defaults and word type for the Huffman output path.
package huffman_pkg;
    localparam int BYTE_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef struct packed {
        logic                  last;
        logic [BYTE_W_DEF-1:0] data;
    } word_t;
endpackage

// File: rtl/byte_fifo.sv
// Small first-word-fall-through FIFO; head entry is visible on o_rdata whenever non-empty.
module byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/bit_packer.sv
// Packs the translator's serial bit stream MSB-first into words, with flush padding,
// and buffers them in a FWFT FIFO. The upstream cannot stall, so drops set a sticky flag.
module bit_packer
    import huffman_pkg::*;
#(
    parameter int BYTE_W     = BYTE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          flush,
    output logic [BYTE_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          flush_done
);
    localparam int CW = $clog2(BYTE_W);

    logic [BYTE_W-1:0] r_sreg;
    logic [CW-1:0]     r_bcnt;
    logic              r_overflow, r_flush_done;

    logic [BYTE_W-1:0] w_shift, w_sreg_nx, w_flush_word;
    logic [CW:0]       w_k, w_sh;
    logic              w_word_done, w_push, w_pop, w_full, w_empty;
    logic [BYTE_W:0]   w_wdata, w_rdata;

    assign w_shift     = {r_sreg[BYTE_W-2:0], bit_in};
    assign w_sreg_nx   = bit_valid ? w_shift : r_sreg;
    assign w_word_done = bit_valid && (r_bcnt == CW'(BYTE_W-1));
    // Pending bits after this cycle's bit; a completed word is handled by w_word_done.
    assign w_k         = {1'b0, r_bcnt} + (CW+1)'(bit_valid);
    assign w_sh        = (CW+1)'(BYTE_W) - w_k;
    // Left-align the k pending bits; stale upper bits shift out, zeros fill in.
    assign w_flush_word = w_sreg_nx << w_sh;

    assign w_push  = w_word_done || (flush && (w_k != '0));
    assign w_wdata = {flush, w_word_done ? w_shift : w_flush_word};
    assign w_pop   = !w_empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sreg       <= '0;
            r_bcnt       <= '0;
            r_overflow   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= flush;
            if (bit_valid)
                r_sreg <= w_shift;
            if (flush || w_word_done)
                r_bcnt <= '0;
            else if (bit_valid)
                r_bcnt <= r_bcnt + 1'b1;
            if (w_push && w_full && !w_pop)
                r_overflow <= 1'b1;
        end
    end

    byte_fifo #(
        .WIDTH (BYTE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    assign out_data   = w_rdata[BYTE_W-1:0];
    assign out_last   = w_rdata[BYTE_W];
    assign out_valid  = !w_empty;
    assign overflow   = r_overflow;
    assign flush_done = r_flush_done;
endmodule

// File: tb/tb_bit_packer.sv
// Directed scoreboard bench for bit_packer: stimulus queues expected words, monitor checks pops.
module tb_bit_packer;
    import huffman_pkg::*;

    logic       clk, rst, bit_in, bit_valid, flush, out_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last, overflow, flush_done;
    logic [2:0] count;

    int    total = 0;
    int    bad   = 0;
    word_t sb[$];

    bit_packer #(.BYTE_W(8), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .count      (count),
        .overflow   (overflow),
        .flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic last, input logic [7:0] data);
        word_t w;
        w.last = last;
        w.data = data;
        sb.push_back(w);
    endtask

    // Drive one bit for one cycle; called at posedge+1, returns at next posedge+1.
    task automatic send_bit(input logic b, input logic fl);
        bit_valid = 1'b1;
        bit_in    = b;
        flush     = fl;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " out_data"},   out_data,   0);
        chk({tag, " out_valid"},  out_valid,  0);
        chk({tag, " out_last"},   out_last,   0);
        chk({tag, " count"},      count,      0);
        chk({tag, " overflow"},   overflow,   0);
        chk({tag, " flush_done"}, flush_done, 0);
    endtask

    // Monitor: every accepted word must match the scoreboard head.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected word: got last=%0d data=%0h, none expected", out_last, out_data);
                end else begin
                    w = sb.pop_front();
                    chk("word data", out_data, w.data);
                    chk("word last", out_last, w.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Full word
        out_ready = 1'b1;
        expect_word(1'b0, 8'hB2);
        send_byte(8'hB2);
        idle(1);
        chk("full word count", count, 0);

        // Partial flush
        expect_word(1'b1, 8'hC0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("partial flush_done", flush_done, 1);
        idle(1);
        chk("partial flush_done low", flush_done, 0);
        chk("partial count", count, 0);

        // Flush on word boundary, then an empty flush
        expect_word(1'b1, 8'hFE);
        repeat (7) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("boundary flush_done", flush_done, 1);
        idle(1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("empty flush_done", flush_done, 1);
        chk("empty flush count", count, 0);
        idle(2);
        chk("boundary words outstanding", sb.size(), 0);

        // Overflow: five words into a four-entry FIFO
        out_ready = 1'b0;
        repeat (4) expect_word(1'b0, 8'hA5);
        repeat (5) send_byte(8'hA5);
        chk("ovf count", count, 4);
        chk("ovf flag", overflow, 1);
        out_ready = 1'b1;
        idle(6);
        chk("ovf drained count", count, 0);
        chk("ovf sticky", overflow, 1);
        chk("ovf words outstanding", sb.size(), 0);

        // Clear overflow, then simultaneous push/pop when full
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        chk("rst clears overflow", overflow, 0);
        out_ready = 1'b0;
        expect_word(1'b0, 8'h11);
        expect_word(1'b0, 8'h22);
        expect_word(1'b0, 8'h33);
        expect_word(1'b0, 8'h44);
        expect_word(1'b0, 8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("full count", count, 4);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h55 >> i), 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        chk("push/pop full count", count, 4);
        chk("push/pop no overflow", overflow, 0);
        idle(6);
        chk("push/pop drained", count, 0);
        chk("push/pop words outstanding", sb.size(), 0);

        // Reset mid-word with a word queued
        out_ready = 1'b0;
        send_byte(8'h99);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        chk_reset_vals("mid-word rst");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_word(1'b0, 8'h3C);
        send_byte(8'h3C);
        idle(4);
        chk("reset recovery count", count, 0);
        chk("final words outstanding", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
